// File: rtl/instr_fetch_pkg.sv
// Shared pipeline constants: instruction width, opcodes and the NOP encoding.
package instr_fetch_pkg;
  localparam int INSTR_W = 32;

  localparam logic [3:0] OP_ALU = 4'd1;
  localparam logic [3:0] OP_LW  = 4'd2;
  localparam logic [3:0] OP_SW  = 4'd3;
  localparam logic [3:0] OP_BR  = 4'd4;

  localparam logic [INSTR_W-1:0] NOP = 32'h0;
endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register: sync reset, hold on stall, squash to NOP on redirect.
module if_id_reg
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_hold,
  input  logic               i_squash,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc,
  input  logic               i_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_valid;

  // Reset and squash both leave a NOP bubble; hold keeps the word for the decoder.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_squash) begin
      r_instr <= NOP;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      r_instr <= i_valid ? i_instr : NOP;
      r_pc    <= i_pc;
      r_valid <= i_valid;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, one in-flight imem read, and the IF/ID register feeding the decoder.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int              ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_en,
  output logic [ADDR_W-3:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] Instruction,
  output logic [ADDR_W-1:0]  id_pc,
  output logic               id_valid
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_req_valid;
  logic [ADDR_W-1:0] r_req_pc;

  logic [ADDR_W-1:0] w_fa;
  logic              w_hold;

  // Fetch address: a redirect bypasses the PC so the target is read this same cycle.
  always_comb begin
    w_fa      = redirect ? {redirect_pc[ADDR_W-1:2], 2'b00} : r_pc;
    imem_addr = rst ? RESET_PC[ADDR_W-1:2] : w_fa[ADDR_W-1:2];
    imem_en   = !rst && (redirect || !stall);
  end

  // Stall only holds when no redirect is pending; redirect always advances.
  assign w_hold = stall && !redirect;

  // PC and in-flight request tracking; the in-flight tag freezes with imem_rdata on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_pc    <= '0;
    end else if (!w_hold) begin
      r_pc        <= w_fa + ADDR_W'(4);
      r_req_valid <= 1'b1;
      r_req_pc    <= w_fa;
    end
  end

  if_id_reg #(.ADDR_W(ADDR_W)) u_if_id (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_hold   (w_hold),
    .i_squash (redirect),
    .i_instr  (imem_rdata),
    .i_pc     (r_req_pc),
    .i_valid  (r_req_valid),
    .o_instr  (Instruction),
    .o_pc     (id_pc),
    .o_valid  (id_valid)
  );

endmodule
